// File: rtl/nvdla_csb_arbiter.sv
// Round-robin sharing of the CSB master port, one access in flight; accept in cycle 0, csb_valid_o in cycle 1, rsp_valid_o one cycle after the CSB response.
// Requesters wait on req_ready_o and CSB issue waits on csb_ready_i; responses are never backpressured and time out after 2**TMO_W-1 waiting cycles.
module nvdla_csb_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 16,
  parameter int TMO_W  = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ*32-1:0]     req_wdata_i,
  input  logic [N_REQ-1:0]        req_write_i,
  input  logic [N_REQ-1:0]        req_nposted_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [31:0]             rsp_data_o,
  output logic                    rsp_err_o,
  output logic                    csb_valid_o,
  input  logic                    csb_ready_i,
  output logic [ADDR_W-1:0]       csb_addr_o,
  output logic [31:0]             csb_wdata_o,
  output logic                    csb_write_o,
  output logic                    csb_nposted_o,
  input  logic                    csb_rvalid_i,
  input  logic [31:0]             csb_rdata_i,
  input  logic                    csb_wr_done_i,
  output logic                    busy_o,
  output logic                    stray_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              write;
    logic              nposted;
  } acc_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  acc_t             acc_q, acc_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             stray_q, stray_d;

  logic             arb_vld;
  logic [IDX_W-1:0] arb_idx;
  int               arb_cand;
  logic             rsp_any, rsp_good, rsp_wrong;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(N_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  // first valid requester at or after the round-robin pointer, cyclically
  always_comb begin
    arb_vld  = 1'b0;
    arb_idx  = '0;
    arb_cand = 0;
    for (int i = 0; i < N_REQ; i++) begin
      arb_cand = (int'(rr_q) + i) % N_REQ;
      if (!arb_vld && req_valid_i[arb_cand]) begin
        arb_vld = 1'b1;
        arb_idx = IDX_W'(arb_cand);
      end
    end
  end

  assign rsp_any   = csb_rvalid_i | csb_wr_done_i;
  assign rsp_good  = acc_q.write ? csb_wr_done_i : csb_rvalid_i;
  assign rsp_wrong = acc_q.write ? csb_rvalid_i : csb_wr_done_i;

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    gnt_d         = gnt_q;
    acc_d         = acc_q;
    timer_d       = timer_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    stray_d       = 1'b0;
    req_ready_o   = '0;
    rsp_valid_o   = '0;
    rsp_data_o    = '0;
    rsp_err_o     = 1'b0;
    csb_valid_o   = 1'b0;
    csb_addr_o    = '0;
    csb_wdata_o   = '0;
    csb_write_o   = 1'b0;
    csb_nposted_o = 1'b0;
    case (state_q)
      IDLE: begin
        stray_d = rsp_any;
        // ready is held low while reset is asserted so every output reads 0
        if (arb_vld && !rst_i) begin
          req_ready_o[arb_idx] = 1'b1;
          gnt_d         = arb_idx;
          acc_d.addr    = req_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
          acc_d.wdata   = req_wdata_i[int'(arb_idx)*32 +: 32];
          acc_d.write   = req_write_i[arb_idx];
          acc_d.nposted = req_nposted_i[arb_idx];
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        stray_d       = rsp_any;
        csb_valid_o   = 1'b1;
        csb_addr_o    = acc_q.addr;
        csb_wdata_o   = acc_q.wdata;
        csb_write_o   = acc_q.write;
        csb_nposted_o = acc_q.nposted;
        if (csb_ready_i) begin
          if (acc_q.write && !acc_q.nposted) begin
            rr_d    = next_idx(gnt_q);
            state_d = IDLE;
          end else begin
            timer_d = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stray_d = rsp_wrong;
        // a genuine response beats a timeout landing in the same cycle
        if (rsp_good) begin
          rdata_d = acc_q.write ? 32'h0 : csb_rdata_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TMO_MAX) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        stray_d             = rsp_any;
        rsp_valid_o[gnt_q]  = 1'b1;
        rsp_data_o          = rdata_q;
        rsp_err_o           = err_q;
        rr_d                = next_idx(gnt_q);
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      acc_q   <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      acc_q   <= acc_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      stray_q <= stray_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign stray_o = stray_q;

endmodule
